sal_axi_w_upsizer: RTL and testbench
====================================

Name: sal_axi_w_upsizer

Overview:
- Upstream neighbour of the DDR write-control stage. Packs a 64-bit host AXI W stream into the 128-bit W stream that the write-data FIFO consumes.
- Two narrow beats are merged into one wide beat; strobes merge lane by lane.
- An odd-length burst pads its final wide beat with zero strobes.
- WID and WLAST are carried through. The downstream B-response path counts one WLAST per burst, so burst framing must be preserved exactly.

Parameters:
- S_DATA_WIDTH, 64, slave-side (host) data width in bits; must be a multiple of 8.
- M_DATA_WIDTH, 128, master-side data width in bits; M_DATA_WIDTH/S_DATA_WIDTH = RATIO, a power of 2, ≥2.
- ID_WIDTH, `AXI_ID_WIDTH, width of the WID field.

Ports:
- clk  in  1  clock; everything in one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- s_wid  in  ID_WIDTH  host write ID.
- s_wdata  in  S_DATA_WIDTH  host write data.
- s_wstrb  in  S_DATA_WIDTH/8  host byte strobes.
- s_wlast  in  1  last beat of the host burst.
- s_wvalid  in  1  host beat valid.
- s_wready  out  1  beat accepted when s_wvalid & s_wready.
- m_wid  out  ID_WIDTH  packed-beat ID.
- m_wdata  out  M_DATA_WIDTH  packed data; lane 0 = bits [S_DATA_WIDTH-1:0].
- m_wstrb  out  M_DATA_WIDTH/8  packed strobes.
- m_wlast  out  1  last packed beat of the burst.
- m_wvalid  out  1  packed beat valid.
- m_wready  in  1  downstream ready (write-data FIFO not full).
- err_interleave_o  out  1  sticky flag: WID changed mid-word.

Behaviour:
- Reset: asynchronous on rst_n low.
  - m_wvalid=0, m_wlast=0, m_wid=0, m_wdata=0, m_wstrb=0.
  - Lane counter cnt=0, accumulator strobes=0, err_interleave_o=0.
  - s_wready=0 while rst_n is low.
  - Reset in the middle of a word drops the partial word; no beat is emitted.
- Alignment: every host burst starts in lane 0. The AW path guarantees 128-bit-aligned start addresses.
- State: cnt (log2 RATIO bits); accumulator acc_data/acc_strb; acc_id; output register out_* with out_valid.
- Ready: s_wready = ~out_valid | m_wready. This is combinational in base mode.
- On each accepted host beat, let lane = cnt:
  - If cnt == RATIO-1 or s_wlast=1 (the beat completes a word):
    - Load the output register with the accumulator, with lane `cnt` replaced by s_wdata/s_wstrb.
    - Lanes above cnt carry data=0 and strb=0.
    - out_last=s_wlast, out_id=s_wid, out_valid=1.
    - Set cnt=0 and acc_strb=0.
  - Otherwise: write s_wdata/s_wstrb into lane cnt of the accumulator, set acc_id=s_wid, and cnt++.
- Output register handshake:
  - out_valid clears on m_wvalid & m_wready unless it is reloaded in the same cycle.
  - A simultaneous drain and load yields back-to-back wide beats.
  - Sustained rate: 1 host beat/cycle; 1 wide beat per RATIO cycles.
- Hold rule: while m_wvalid=1 and m_wready=0, m_* holds stable (AXI rule).
- Interleave error: accepted beat with cnt≠0 and s_wid≠acc_id sets err_interleave_o=1 until reset.
  - The beat is still packed, and out_id takes the newer WID.
- Latency: a completing host beat appears on m_* in the next cycle.
- Strobes pass unmodified. Inversion to a mask happens downstream.

Optional Feature:
- Macro: SAL_W_UPSIZER_SKID_EN.
- Defined: the output register becomes a 2-entry skid buffer.
  - s_wready = ~buffer_full, registered.
  - There is no combinational path from m_wready to s_wready.
  - Latency stays 1 cycle; throughput is unchanged.
  - At most two wide beats are buffered.
- Not defined: single output register as above, with the combinational ready path.

Decomposition:
- Shared package (sal_axi_pkg): S/M data-width defaults, the RATIO constant function, and a packed struct {id, data, strb, last} for a wide W beat.
- One sub-module: sal_skid_buf, a generic 2-entry valid/ready register slice parameterised by payload width. It is instantiated only under SAL_W_UPSIZER_SKID_EN.

Test Plan:
- Aligned 4-beat burst: WID=3, data 0x11..,0x22..,0x33..,0x44.., strb 0xFF each, m_wready=1 -> two wide beats: {0x22..,0x11..} strb 0xFFFF last=0, then {0x44..,0x33..} strb 0xFFFF last=1, m_wid=3.
- Odd 3-beat burst (WID=5, strb 0x0F,0xF0,0xFF) -> beat 1 strb 0xF00F; beat 2 upper lane data=0, strb 0x00FF, last=1.
- Backpressure: m_wready=0 for 5 cycles during a 6-beat stream -> s_wready drops after the first word completes; m_* stable throughout; no beat lost or duplicated; all 3 wide beats in order.
- Single-beat burst (wlast on beat 1) followed immediately by a new burst with a different WID -> first wide beat strb 0x00FF last=1; err_interleave_o stays 0.
- WID change at lane 1 (beat 0 WID=1, beat 1 WID=2, wlast=1) -> err_interleave_o=1 and stays 1; m_wid=2.
- Assert rst_n=0 after beat 0 of a word -> m_wvalid=0 immediately; after release, the next burst packs from lane 0 with no stale strobes.

Source files
------------

// File: rtl/sal_axi_pkg.sv
// Shared AXI width defaults, width-ratio helper and wide W-beat layout
// used by the W-channel upsizer and its bench.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package sal_axi_pkg;

  localparam int unsigned SAL_S_DW = 64;
  localparam int unsigned SAL_M_DW = 128;
  localparam int unsigned SAL_ID_W = `AXI_ID_WIDTH;

  function automatic int unsigned sal_ratio(input int unsigned s_dw, input int unsigned m_dw);
    return m_dw / s_dw;
  endfunction

  typedef struct packed {
    logic [SAL_ID_W-1:0]   id;
    logic [SAL_M_DW-1:0]   data;
    logic [SAL_M_DW/8-1:0] strb;
    logic                  last;
  } sal_w_beat_t;

endpackage

// File: rtl/sal_skid_buf.sv
// Generic 2-entry valid/ready register slice; in_ready_o is registered so
// there is no combinational path from out_ready_i back to the producer.
module sal_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  assign push        = in_valid_i & rdy_q;
  assign pop         = (cnt_q != 2'd0) & out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign in_ready_o  = rdy_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push && pop) begin
      if (cnt_q == 2'd1) begin
        head_d = in_data_i;
      end else begin
        head_d = tail_q;
        tail_d = in_data_i;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) head_d = in_data_i;
      else               tail_d = in_data_i;
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/sal_axi_w_upsizer.sv
// Packs narrow host AXI W beats into wide W beats, preserving WID/WLAST framing.
// Define SAL_W_UPSIZER_SKID_EN to replace the output register with a 2-entry skid buffer.
module sal_axi_w_upsizer
  import sal_axi_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = SAL_S_DW,
  parameter int unsigned M_DATA_WIDTH = SAL_M_DW,
  parameter int unsigned ID_WIDTH     = `AXI_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ID_WIDTH-1:0]       s_wid,
  input  logic [S_DATA_WIDTH-1:0]   s_wdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                      s_wlast,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [ID_WIDTH-1:0]       m_wid,
  output logic [M_DATA_WIDTH-1:0]   m_wdata,
  output logic [M_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic                      err_interleave_o
);

  localparam int unsigned RATIO = sal_ratio(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int unsigned CW    = $clog2(RATIO);
  localparam int unsigned SB    = S_DATA_WIDTH / 8;
  localparam int unsigned MB    = M_DATA_WIDTH / 8;
  localparam int unsigned PW    = ID_WIDTH + M_DATA_WIDTH + MB + 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d, ld_data;
  logic [MB-1:0]           acc_strb_q, acc_strb_d, ld_strb;
  logic [ID_WIDTH-1:0]     acc_id_q, acc_id_d;
  logic                    err_q, err_d;
  logic                    accept, complete, load;
  logic [PW-1:0]           ld_beat, out_beat;

  assign accept   = s_wvalid & s_wready;
  assign complete = (cnt_q == CW'(RATIO - 1)) | s_wlast;
  assign load     = accept & complete;

  // Accumulator data is never cleared, so lanes above cnt are masked to zero here.
  always_comb begin
    ld_data = '0;
    ld_strb = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt_q) begin
        ld_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = acc_data_q[i*S_DATA_WIDTH +: S_DATA_WIDTH];
        ld_strb[i*SB +: SB]                     = acc_strb_q[i*SB +: SB];
      end else if (CW'(i) == cnt_q) begin
        ld_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_wdata;
        ld_strb[i*SB +: SB]                     = s_wstrb;
      end
    end
  end

  assign ld_beat = {s_wid, ld_data, ld_strb, s_wlast};

  always_comb begin
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_strb_d = acc_strb_q;
    acc_id_d   = acc_id_q;
    err_d      = err_q | (accept && (cnt_q != '0) && (s_wid != acc_id_q));
    if (accept) begin
      if (complete) begin
        cnt_d      = '0;
        acc_strb_d = '0;
      end else begin
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (CW'(i) == cnt_q) begin
            acc_data_d[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_wdata;
            acc_strb_d[i*SB +: SB]                     = s_wstrb;
          end
        end
        acc_id_d = s_wid;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_strb_q <= '0;
      acc_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_strb_q <= acc_strb_d;
      acc_id_q   <= acc_id_d;
      err_q      <= err_d;
    end
  end

  assign err_interleave_o = err_q;

`ifdef SAL_W_UPSIZER_SKID_EN
  logic buf_ready;

  sal_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (load),
    .in_ready_o  (buf_ready),
    .in_data_i   (ld_beat),
    .out_valid_o (m_wvalid),
    .out_ready_i (m_wready),
    .out_data_o  (out_beat)
  );

  assign s_wready = buf_ready;
`else
  logic [PW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;

  assign s_wready = rst_n & (~out_valid_q | m_wready);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && m_wready) out_valid_d = 1'b0;
    if (load) begin
      out_d       = ld_beat;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_beat = out_q;
  assign m_wvalid = out_valid_q;
`endif

  assign {m_wid, m_wdata, m_wstrb, m_wlast} = out_beat;

endmodule

// File: tb/tb_sal_axi_w_upsizer.sv
// Directed self-checking bench for sal_axi_w_upsizer (64->128, 4-bit WID).
module tb_sal_axi_w_upsizer;

  localparam int unsigned IDW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   s_wid;
  logic [63:0]  s_wdata;
  logic [7:0]   s_wstrb;
  logic         s_wlast, s_wvalid, s_wready;
  logic [3:0]   m_wid;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic         err_interleave_o;

  int tests = 0;
  int failed = 0;

  localparam logic [63:0] D1 = 64'h1111111111111111;
  localparam logic [63:0] D2 = 64'h2222222222222222;
  localparam logic [63:0] D3 = 64'h3333333333333333;
  localparam logic [63:0] D4 = 64'h4444444444444444;
  localparam logic [63:0] E0 = 64'hA0A0A0A0A0A0A0A0;
  localparam logic [63:0] E1 = 64'hA1A1A1A1A1A1A1A1;
  localparam logic [63:0] E2 = 64'hA2A2A2A2A2A2A2A2;
  localparam logic [63:0] E3 = 64'hA3A3A3A3A3A3A3A3;
  localparam logic [63:0] E4 = 64'hA4A4A4A4A4A4A4A4;
  localparam logic [63:0] E5 = 64'hA5A5A5A5A5A5A5A5;

  sal_axi_w_upsizer #(
    .S_DATA_WIDTH(64),
    .M_DATA_WIDTH(128),
    .ID_WIDTH    (IDW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_wid            (s_wid),
    .s_wdata          (s_wdata),
    .s_wstrb          (s_wstrb),
    .s_wlast          (s_wlast),
    .s_wvalid         (s_wvalid),
    .s_wready         (s_wready),
    .m_wid            (m_wid),
    .m_wdata          (m_wdata),
    .m_wstrb          (m_wstrb),
    .m_wlast          (m_wlast),
    .m_wvalid         (m_wvalid),
    .m_wready         (m_wready),
    .err_interleave_o (err_interleave_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] id, input logic [127:0] data,
                          input logic [15:0] strb, input logic last);
    chk({tag, ".valid"}, 256'(m_wvalid), 256'(1'b1));
    chk({tag, ".id"},    256'(m_wid),    256'(id));
    chk({tag, ".data"},  256'(m_wdata),  256'(data));
    chk({tag, ".strb"},  256'(m_wstrb),  256'(strb));
    chk({tag, ".last"},  256'(m_wlast),  256'(last));
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [3:0] id, input logic [63:0] data, input logic [7:0] strb,
                      input logic last);
    logic ok;
    ok = 1'b0;
    s_wid = id; s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = s_wready;
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (!ok) begin
      tests++;
      failed++;
      $error("FAIL send_timeout: observed s_wready=0 expected acceptance within 20 cycles");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; m_wready = 1'b1;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("rst.m_wvalid", 256'(m_wvalid), 256'(0));
    chk("rst.s_wready", 256'(s_wready), 256'(0));
    chk("rst.m_wdata",  256'(m_wdata),  256'(0));
    chk("rst.m_wstrb",  256'(m_wstrb),  256'(0));
    chk("rst.err",      256'(err_interleave_o), 256'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // aligned 4-beat burst
    send(4'd3, D1, 8'hFF, 1'b0);
    chk("b4.w0_not_yet", 256'(m_wvalid), 256'(0));
    send(4'd3, D2, 8'hFF, 1'b0);
    chk_beat("b4.w0", 4'd3, {D2, D1}, 16'hFFFF, 1'b0);
    send(4'd3, D3, 8'hFF, 1'b0);
    chk("b4.drained", 256'(m_wvalid), 256'(0));
    send(4'd3, D4, 8'hFF, 1'b1);
    chk_beat("b4.w1", 4'd3, {D4, D3}, 16'hFFFF, 1'b1);
    idle();

    // odd 3-beat burst: final wide beat padded
    send(4'd5, D1, 8'h0F, 1'b0);
    send(4'd5, D2, 8'hF0, 1'b0);
    chk_beat("b3.w0", 4'd5, {D2, D1}, 16'hF00F, 1'b0);
    send(4'd5, D3, 8'hFF, 1'b1);
    chk_beat("b3.w1", 4'd5, {64'h0, D3}, 16'h00FF, 1'b1);
    idle();

    // backpressure over a 6-beat stream
    m_wready = 1'b0;
    send(4'd4, E0, 8'hFF, 1'b0);
    send(4'd4, E1, 8'hFF, 1'b0);
    chk_beat("bp.w0", 4'd4, {E1, E0}, 16'hFFFF, 1'b0);
    chk("bp.s_wready_low", 256'(s_wready), 256'(0));
    s_wid = 4'd4; s_wdata = E2; s_wstrb = 8'hFF; s_wlast = 1'b0; s_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk_beat("bp.hold", 4'd4, {E1, E0}, 16'hFFFF, 1'b0);
      chk("bp.hold_ready", 256'(s_wready), 256'(0));
    end
    m_wready = 1'b1;
    idle();
    s_wvalid = 1'b0;
    chk("bp.no_dup", 256'(m_wvalid), 256'(0));
    send(4'd4, E3, 8'hFF, 1'b0);
    chk_beat("bp.w1", 4'd4, {E3, E2}, 16'hFFFF, 1'b0);
    send(4'd4, E4, 8'hFF, 1'b0);
    send(4'd4, E5, 8'hFF, 1'b1);
    chk_beat("bp.w2", 4'd4, {E5, E4}, 16'hFFFF, 1'b1);
    idle();

    // single-beat burst then new burst with a different WID
    send(4'd7, D1, 8'hFF, 1'b1);
    chk_beat("sb.w0", 4'd7, {64'h0, D1}, 16'h00FF, 1'b1);
    send(4'd9, D2, 8'hFF, 1'b0);
    send(4'd9, D3, 8'hFF, 1'b1);
    chk_beat("sb.w1", 4'd9, {D3, D2}, 16'hFFFF, 1'b1);
    chk("sb.err", 256'(err_interleave_o), 256'(0));
    idle();

    // WID change mid-word
    send(4'd1, D1, 8'hFF, 1'b0);
    send(4'd2, D2, 8'hFF, 1'b1);
    chk_beat("il.w0", 4'd2, {D2, D1}, 16'hFFFF, 1'b1);
    chk("il.err", 256'(err_interleave_o), 256'(1));
    idle();
    idle();
    chk("il.err_sticky", 256'(err_interleave_o), 256'(1));

    // reset in the middle of a word
    send(4'd6, D1, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.m_wvalid", 256'(m_wvalid), 256'(0));
    chk("mr.s_wready", 256'(s_wready), 256'(0));
    chk("mr.err",      256'(err_interleave_o), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    send(4'd10, D4, 8'h0F, 1'b1);
    chk_beat("mr.w0", 4'd10, {64'h0, D4}, 16'h000F, 1'b1);
    idle();
    chk("mr.drained", 256'(m_wvalid), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
